// File: rtl/mpt_tlb.sv
// ---------------------------------------------------------------------------
// mpt_tlb : small fully associative cache of memory-protection permissions.
//
// It sits in front of the MTT page-table walker. Hits are answered locally.
// On a miss it drives the walker control port, waits for the walker's result,
// installs the permissions and then answers the requester. Only one request
// is in flight at a time, and tags are page-granular.
//
// Optional feature macro: MPT_TLB_STATS_EN (adds hit/miss counters).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               invalidate all entries (takes effect on next edge)
//   req_valid_i/ready_o   access-check handshake
//   req_paddr_i           physical address to check
//   req_access_i          0=read 1=write 2=execute 3=reserved
//   resp_valid_o          one-cycle response strobe
//   resp_allow_o          access permitted
//   resp_fault_o          walker/format fault (allow forced 0)
//   hit_count_o           [MPT_TLB_STATS_EN] saturating hit counter
//   miss_count_o          [MPT_TLB_STATS_EN] saturating miss counter
//   ptw_enable_o          walker enable
//   ptw_addr_valid_o      walker address valid (one-cycle pulse)
//   ptw_paddr_o           walker address
//   ptw_valid_i           walker result valid
//   ptw_perm_i            {x,w,r} permissions from the walker
//   ptw_fault_i           walker access/format fault
// ---------------------------------------------------------------------------
module mpt_tlb #(
   parameter int PLEN        = 56,
   parameter int TLB_ENTRIES = 4,
   parameter int PAGE_SHIFT  = 12
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [PLEN-1:0] req_paddr_i,
   input  logic [1:0]      req_access_i,
   output logic            resp_valid_o,
   output logic            resp_allow_o,
   output logic            resp_fault_o,
`ifdef MPT_TLB_STATS_EN
   output logic [31:0]     hit_count_o,
   output logic [31:0]     miss_count_o,
`endif
   output logic            ptw_enable_o,
   output logic            ptw_addr_valid_o,
   output logic [PLEN-1:0] ptw_paddr_o,
   input  logic            ptw_valid_i,
   input  logic [2:0]      ptw_perm_i,
   input  logic            ptw_fault_i
);

   localparam int TAG_W = PLEN - PAGE_SHIFT;
   localparam int IDX_W = $clog2(TLB_ENTRIES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHECK     = 3'd1,
      WALK_REQ  = 3'd2,
      WALK_WAIT = 3'd3,
      RESP      = 3'd4
   } state_t;

   state_t state_reg, state_next;

   logic [PLEN-1:0]        paddr_reg;
   logic [1:0]             access_reg;
   logic                   allow_reg;
   logic                   fault_reg;
   logic [TLB_ENTRIES-1:0] valid_reg;
   logic [IDX_W-1:0]       ptr_reg;
   logic [TAG_W-1:0]       tag_reg  [TLB_ENTRIES];
   logic [2:0]             perm_reg [TLB_ENTRIES];

   logic [TAG_W-1:0]       req_tag;
   logic [TLB_ENTRIES-1:0] hit_vec;
   logic                   hit_any;
   logic [2:0]             hit_perm;
   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       install_idx;
   logic                   install_we;
   logic                   check_done;

   // Reserved access code (3) never grants permission.
   function automatic logic perm_bit(input logic [2:0] p, input logic [1:0] a);
      case (a)
         2'd0:    perm_bit = p[0];
         2'd1:    perm_bit = p[1];
         2'd2:    perm_bit = p[2];
         default: perm_bit = 1'b0;
      endcase
   endfunction

   assign req_tag = paddr_reg[PLEN-1:PAGE_SHIFT];

   genvar gi;
   generate
      for (gi = 0; gi < TLB_ENTRIES; gi++) begin : g_cmp
         assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
      end
   endgenerate

   assign hit_any = |hit_vec;

   // Tags are unique, so at most one entry matches and an OR-reduction of
   // the masked permissions is an exact select.
   always_comb begin
      hit_perm = 3'b000;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (hit_vec[i]) hit_perm = hit_perm | perm_reg[i];
      end
   end

   // Lowest-index invalid entry: scan downward so the last assignment wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_reg[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign install_idx = free_found ? free_idx : ptr_reg;
   // A fault wins over a simultaneous valid; a flush in the same cycle
   // suppresses the install but not the response.
   assign install_we  = (state_reg == WALK_WAIT) && ptw_valid_i && !ptw_fault_i && !flush_i;
   // A flush during CHECK holds the lookup one more cycle so it is redone
   // against the emptied table.
   assign check_done  = (state_reg == CHECK) && !flush_i;

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (req_valid_i) state_next = CHECK;
         CHECK: begin
            if (flush_i)                              state_next = CHECK;
            else if (hit_any || access_reg == 2'd3)   state_next = RESP;
            else                                      state_next = WALK_REQ;
         end
         WALK_REQ:  state_next = WALK_WAIT;
         WALK_WAIT: if (ptw_fault_i || ptw_valid_i) state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      req_ready_o      = (state_reg == IDLE) && !rst_i;
      resp_valid_o     = (state_reg == RESP);
      resp_allow_o     = (state_reg == RESP) && allow_reg;
      resp_fault_o     = (state_reg == RESP) && fault_reg;
      ptw_enable_o     = (state_reg == WALK_REQ) || (state_reg == WALK_WAIT);
      ptw_addr_valid_o = (state_reg == WALK_REQ);
      ptw_paddr_o      = ptw_enable_o ? paddr_reg : '0;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         paddr_reg  <= '0;
         access_reg <= 2'd0;
         allow_reg  <= 1'b0;
         fault_reg  <= 1'b0;
         valid_reg  <= '0;
         ptr_reg    <= '0;
      end else begin
         if (state_reg == IDLE && req_valid_i) begin
            paddr_reg  <= req_paddr_i;
            access_reg <= req_access_i;
         end

         if (check_done) begin
            allow_reg <= hit_any && perm_bit(hit_perm, access_reg);
            fault_reg <= 1'b0;
         end

         if (state_reg == WALK_WAIT) begin
            if (ptw_fault_i) begin
               allow_reg <= 1'b0;
               fault_reg <= 1'b1;
            end else if (ptw_valid_i) begin
               allow_reg <= perm_bit(ptw_perm_i, access_reg);
               fault_reg <= 1'b0;
            end
         end

         if (install_we) begin
            valid_reg[install_idx] <= 1'b1;
            if (!free_found) ptr_reg <= ptr_reg + IDX_W'(1);
         end

         if (flush_i) begin
            valid_reg <= '0;
            ptr_reg   <= '0;
         end
      end
   end

   // Tag/permission storage needs no reset: valid_reg gates every use.
   always_ff @(posedge clk_i) begin
      if (install_we) begin
         tag_reg[install_idx]  <= req_tag;
         perm_reg[install_idx] <= ptw_perm_i;
      end
   end

`ifdef MPT_TLB_STATS_EN
   logic [31:0] hit_cnt_reg;
   logic [31:0] miss_cnt_reg;

   // Reserved access counts as a miss even if the page is cached.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else if (check_done) begin
         if (hit_any && access_reg != 2'd3) begin
            if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end else begin
            if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
         end
      end
   end

   assign hit_count_o  = hit_cnt_reg;
   assign miss_count_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_mpt_tlb.sv
// ---------------------------------------------------------------------------
// tb_mpt_tlb : directed self-checking bench for mpt_tlb. Expected responses
// are queued when a request is issued and compared when resp_valid_o fires.
// Walker behaviour, latency and walk pulses are checked per request.
// ---------------------------------------------------------------------------
module tb_mpt_tlb;
   localparam int PLEN = 56;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [PLEN-1:0] req_paddr = '0;
   logic [1:0]      req_access = 2'd0;
   logic            resp_valid, resp_allow, resp_fault;
   logic            ptw_enable, ptw_addr_valid;
   logic [PLEN-1:0] ptw_paddr;
   logic            ptw_valid = 1'b0;
   logic [2:0]      ptw_perm = 3'b000;
   logic            ptw_fault = 1'b0;
`ifdef MPT_TLB_STATS_EN
   logic [31:0]     hit_count, miss_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] exp_q[$];   // {allow, fault}

   always #5 clk = ~clk;

   mpt_tlb #(.PLEN(PLEN), .TLB_ENTRIES(4), .PAGE_SHIFT(12)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_paddr_i(req_paddr), .req_access_i(req_access),
      .resp_valid_o(resp_valid), .resp_allow_o(resp_allow), .resp_fault_o(resp_fault),
`ifdef MPT_TLB_STATS_EN
      .hit_count_o(hit_count), .miss_count_o(miss_count),
`endif
      .ptw_enable_o(ptw_enable), .ptw_addr_valid_o(ptw_addr_valid), .ptw_paddr_o(ptw_paddr),
      .ptw_valid_i(ptw_valid), .ptw_perm_i(ptw_perm), .ptw_fault_i(ptw_fault)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response scoreboard.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", resp_valid, 1'b0);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check("resp_allow", resp_allow, e[1]);
            check("resp_fault", resp_fault, e[0]);
            $display("resp allow=%0b fault=%0b (exp %0b/%0b)", resp_allow, resp_fault, e[1], e[0]);
         end
      end
   end

   // One request from handshake to response, acting as the walker if asked.
   // Cycle n counts negedges after the handshake edge (n=1 is CHECK).
   task automatic do_access(input string tag, input logic [PLEN-1:0] pa, input logic [1:0] acc,
                            input bit exp_walk, input int dly, input logic [2:0] perm,
                            input bit flt, input bit flush_res, input bit flush_chk,
                            input bit ea, input bit ef);
      int walk_n, resp_n, pulses;
      walk_n = -1; resp_n = -1; pulses = 0;
      exp_q.push_back({ea, ef});
      @(negedge clk);
      check({tag, "/ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_paddr = pa; req_access = acc;
      for (int n = 1; n <= 80 && resp_n < 0; n++) begin
         @(negedge clk);
         req_valid = 1'b0; ptw_valid = 1'b0; ptw_fault = 1'b0; flush = 1'b0;
         if (n == 1 && flush_chk) flush = 1'b1;
         if (resp_valid) resp_n = n;
         if (ptw_addr_valid) begin
            pulses++;
            if (walk_n < 0) begin
               walk_n = n;
               check({tag, "/ptw_paddr"}, ptw_paddr, pa);
            end
         end
         if (walk_n >= 0 && n == walk_n + 1)
            check({tag, "/wait_en"}, {ptw_enable, ptw_addr_valid}, 2'b10);
         if (walk_n >= 0 && n == walk_n + dly) begin
            ptw_valid = 1'b1; ptw_fault = flt; ptw_perm = perm; flush = flush_res;
         end
      end
      ptw_valid = 1'b0; ptw_fault = 1'b0; flush = 1'b0;
      check({tag, "/resp_seen"}, resp_n >= 0, 1'b1);
      check({tag, "/walk_pulses"}, pulses, exp_walk);
      if (exp_walk) begin
         check({tag, "/walk_cycle"}, walk_n, 2 + flush_chk);
         check({tag, "/latency"}, resp_n, walk_n + dly + 1);
      end else begin
         check({tag, "/latency"}, resp_n, 2);
      end
      $display("txn %s pa=%0h acc=%0d walk=%0d resp_cycle=%0d", tag, pa, acc, walk_n, resp_n);
   endtask

   task automatic flush_pulse();
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      $display("txn flush");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int found, resp_seen;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst/ready", req_ready, 1'b0);
      check("rst/outs", {resp_valid, resp_allow, resp_fault, ptw_enable, ptw_addr_valid}, 5'b0);
      check("rst/paddr", ptw_paddr, 56'h0);
`ifdef MPT_TLB_STATS_EN
      check("rst/hits", hit_count, 32'd0);
      check("rst/misses", miss_count, 32'd0);
`endif
      rst = 1'b0;

      // Cold miss, hit, fault, re-walk, reserved access
      do_access("cold",   56'h0000_8000_1234, 2'd0, 1, 5, 3'b001, 0, 0, 0, 1, 0);
      do_access("hit_w",  56'h0000_8000_1FF0, 2'd1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      do_access("hit_r",  56'h0000_8000_1000, 2'd0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      do_access("fault",  56'h0000_9000_0000, 2'd2, 1, 3, 3'b111, 1, 0, 0, 0, 1);
      do_access("refill", 56'h0000_9000_0000, 2'd2, 1, 2, 3'b100, 0, 0, 0, 1, 0);
      do_access("rsvd",   56'h0000_A000_0000, 2'd3, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      flush_pulse();
      do_access("postfl", 56'h0000_8000_1234, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      flush_pulse();
      check("ptr_after_flush", dut.ptr_reg, 2'd0);

      // Replacement: fill, then round-robin from index 0
      do_access("fill1", 56'h1000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      do_access("fill2", 56'h2000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      do_access("fill3", 56'h3000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      do_access("fill4", 56'h4000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      check("ptr_full", dut.ptr_reg, 2'd0);
      do_access("rr5", 56'h5000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      check("ptr_rr5", dut.ptr_reg, 2'd1);
      do_access("rr6", 56'h6000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      do_access("h3", 56'h3000, 2'd0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      do_access("h4", 56'h4000, 2'd0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      do_access("h5", 56'h5000, 2'd0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      do_access("h6", 56'h6000, 2'd0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      do_access("m1", 56'h1000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);   // idx2
      do_access("m3", 56'h3000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);   // idx3, ptr wraps
      check("ptr_wrap", dut.ptr_reg, 2'd0);
      do_access("m4", 56'h4000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);   // idx0
      check("ptr_m4", dut.ptr_reg, 2'd1);

      // Flush colliding with the walker result
      do_access("fl_col", 56'h7000, 2'd0, 1, 2, 3'b111, 0, 1, 0, 1, 0);
      check("ptr_fl_col", dut.ptr_reg, 2'd0);
      do_access("fl_miss", 56'h7000, 2'd0, 1, 1, 3'b000, 0, 0, 0, 0, 0);
      do_access("fl_m4",   56'h4000, 2'd0, 1, 1, 3'b001, 0, 0, 0, 1, 0);
      // Flush during CHECK forces a walk for a cached page
      do_access("fl_chk",  56'h4000, 2'd1, 1, 1, 3'b010, 0, 0, 1, 1, 0);

      // Reset while waiting on the walker
      @(negedge clk);
      req_valid = 1'b1; req_paddr = 56'h0000_B000_0000; req_access = 2'd0;
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (ptw_enable && !ptw_addr_valid) found = 1;
      end
      check("rstw/reached_wait", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rstw/ptw_enable", ptw_enable, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("rstw/ready", req_ready, 1'b1);
`ifdef MPT_TLB_STATS_EN
      check("rstw/hits", hit_count, 32'd0);
      check("rstw/misses", miss_count, 32'd0);
`endif
      resp_seen = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (resp_valid) resp_seen++;
      end
      check("rstw/no_resp", resp_seen, 0);
      $display("txn reset_in_walk");

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mpt_tlb.md
Name: mpt_tlb

Overview:
- Small fully associative cache of memory-protection permissions, directly upstream of the MTT page-table walker.
- Accepts access checks from the core/LSU and answers hits locally.
- On a miss, drives the walker's control port (ptw_enable/addr_valid/paddr), waits for its result, installs the permissions and answers the requester.
- Page-granular tags; one outstanding request at a time.

Parameters:
- PLEN, 56, physical address width (matches mpt_pkg).
- TLB_ENTRIES, 4, number of entries (power of two, ≥2).
- PAGE_SHIFT, 12, page offset bits; tag = paddr[PLEN-1:PAGE_SHIFT].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  invalidate all entries
- req_valid_i  in  1  access check request
- req_ready_o  out  1  request accepted when valid&&ready
- req_paddr_i  in  PLEN  physical address to check
- req_access_i  in  2  0=read, 1=write, 2=execute, 3=reserved
- resp_valid_o  out  1  one-cycle response strobe
- resp_allow_o  out  1  access permitted
- resp_fault_o  out  1  walker or format fault (allow forced 0)
- ptw_enable_o  out  1  walker enable
- ptw_addr_valid_o  out  1  walker address valid
- ptw_paddr_o  out  PLEN  walker address
- ptw_valid_i  in  1  walker result valid
- ptw_perm_i  in  3  {x,w,r} permissions from walker
- ptw_fault_i  in  1  walker access/format fault

Behaviour:
- Reset values: all outputs 0; all entries invalid; replacement pointer 0; FSM in IDLE.
- States and transitions:
  - IDLE: req_ready_o=1. On handshake, latch paddr and access; go to CHECK.
  - CHECK: compare the latched tag against all valid entries. On a hit, compute allow=perm[access] and go to RESP. On a miss, go to WALK_REQ.
  - WALK_REQ: ptw_enable_o=1, ptw_addr_valid_o=1 and ptw_paddr_o=latched paddr for exactly one cycle; go to WALK_WAIT.
  - WALK_WAIT: ptw_enable_o=1, ptw_addr_valid_o=0, ptw_paddr_o held.
    - ptw_fault_i=1: set resp_fault=1, allow=0, no install; go to RESP. Fault has priority over ptw_valid_i in the same cycle.
    - ptw_valid_i=1: install {tag, perm}, set allow=ptw_perm_i[access]; go to RESP.
  - RESP: resp_valid_o=1 with registered allow/fault for one cycle; go to IDLE. req_ready_o=0 in every state except IDLE.
- Latency:
  - Hit: resp_valid_o is high in the 3rd cycle counting the handshake cycle as cycle 1 (IDLE→CHECK→RESP).
  - Miss: resp_valid_o is high the cycle after the walker result cycle.
- req_access_i=3 always yields allow=0, fault=0. No walk is started on a miss with access 3; go straight to RESP.
- Replacement:
  - Install into the lowest-index invalid entry, if any.
  - Otherwise install at the round-robin pointer, then increment the pointer modulo TLB_ENTRIES (wraps from TLB_ENTRIES-1 to 0).
  - The pointer advances only on installs into full TLBs.
- A duplicate tag is never created: a miss implies the tag is absent, and only one request is in flight.
- Flush:
  - All valid bits clear on the next edge, in any state.
  - Flush in the same cycle as an install: flush wins and the entry is not installed. The pending response is still delivered with the walker's permissions.
  - Flush in CHECK forces a miss evaluation the following cycle. The request is re-evaluated after the flush takes effect, so CHECK stays one extra cycle.
  - The replacement pointer resets to 0 on flush.
- Reset mid-operation: FSM returns to IDLE and ptw_enable_o drops the next cycle. Any in-flight response is lost; the requester must reissue.

Optional Feature:
- Macro: MPT_TLB_STATS_EN.
- When defined:
  - Adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - Counters increment in CHECK on hit and miss respectively (access 3 counts as a miss without a walk).
  - Counters saturate at 32'hFFFF_FFFF.
  - Counters are cleared by rst_i only, not by flush_i.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: read of 0x0000_8000_1234; walker returns perm=3'b001 after 5 cycles → exactly one ptw_addr_valid_o pulse with paddr 0x0000_8000_1234; resp allow=1, fault=0; entry installed at index 0.
- Hit: write to 0x0000_8000_1FF0 after the above → no walker activity; resp_valid_o in cycle 3 with allow=0 (w=0).
- Fault: execute of 0x0000_9000_0000; walker asserts ptw_fault_i and ptw_valid_i in the same cycle → resp fault=1, allow=0; nothing installed; the next access to that page walks again.
- Replacement wrap: fill pages 0x1000, 0x2000, 0x3000, 0x4000, then miss on 0x5000 → installs at index 0; a miss on 0x6000 installs at index 1; an access to 0x1000 misses.
- Flush collision: assert flush_i in the ptw_valid_i cycle (perm=3'b111) → resp allow=1; the same page then misses; the pointer reads 0.
- Reset during WALK_WAIT: rst_i high for 1 cycle → ptw_enable_o=0, req_ready_o=1 the next cycle, no resp_valid_o; with MPT_TLB_STATS_EN, both counters read 0.
